data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache that serves the MEM stage's loads and stores.
- It sits between the EX/MEM pipeline registers and a multi-cycle backing data memory.
- It drops `is_ready` while servicing a miss so that the hazard logic can stall the pipeline.
- Word-granular accesses only; 16-byte lines (4 words).

---
 rtl/data_cache.sv | 169 ++++++++++++++++
 tb/tb_data_cache.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage; hits pulse is_output_valid one
// cycle after acceptance, misses hold is_ready low while the victim is written back and the line is refilled.
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                addr,
  input  logic [31:0]                din,
  input  logic                       mem_read,
  input  logic                       mem_write,
  output logic                       is_ready,
  output logic                       is_output_valid,
  output logic [31:0]                dout,
  output logic                       is_hit,
  output logic                       mem_req_valid,
  output logic                       mem_req_write,
  output logic [31:0]                mem_req_addr,
  output logic [LINE_WORDS*32-1:0]   mem_req_wdata,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0]   mem_resp_rdata,
  output logic [31:0]                hit_count,
  output logic [31:0]                access_count
);
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = 32 - 4 - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, TAG, WRITEBACK, ALLOCATE, FILL_WAIT} state_t;
  state_t state;

  logic [TAG_BITS-1:0]        tag_arr  [NUM_SETS];
  logic [LINE_WORDS*32-1:0]   data_arr [NUM_SETS];
  logic [NUM_SETS-1:0]        valid;
  logic [NUM_SETS-1:0]        dirty;

  logic [TAG_BITS-1:0]        req_tag;
  logic [INDEX_BITS-1:0]      req_idx;
  logic [1:0]                 req_off;
  logic [31:0]                req_din;
  logic                       req_write;
  logic                       lookup_hit;

  logic [INDEX_BITS-1:0]      in_idx;
  logic [TAG_BITS-1:0]        in_tag;
  logic [1:0]                 in_off;
  logic                       accept;
  logic                       in_hit;
  logic                       store_hit;
  logic                       fill;
  logic [LINE_WORDS*32-1:0]   fill_line;
  logic                       unused_addr_bits;

  assign in_idx           = addr[4 +: INDEX_BITS];
  assign in_tag           = addr[31 -: TAG_BITS];
  assign in_off           = addr[3:2];
  assign unused_addr_bits = ^addr[1:0];
  assign accept           = (state == IDLE) && (mem_read || mem_write);
  assign in_hit           = valid[in_idx] && (tag_arr[in_idx] == in_tag);
  assign store_hit        = accept && mem_write && in_hit;
  assign fill             = (state == FILL_WAIT) && mem_resp_valid;

  // A store miss merges its word into the incoming line so the refill already holds the new data.
  always_comb begin
    fill_line = mem_resp_rdata;
    if (req_write) fill_line[{req_off, 5'b0} +: 32] = req_din;
  end

  always_ff @(posedge clk) begin
    if (store_hit) data_arr[in_idx][{in_off, 5'b0} +: 32] <= din;
    if (fill) begin
      data_arr[req_idx] <= fill_line;
      tag_arr[req_idx]  <= req_tag;
    end
  end

  // The lookup is resolved on the accepting edge so the TAG cycle already carries the registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      valid           <= '0;
      dirty           <= '0;
      req_tag         <= '0;
      req_idx         <= '0;
      req_off         <= '0;
      req_din         <= '0;
      req_write       <= 1'b0;
      lookup_hit      <= 1'b0;
      is_ready        <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= '0;
      is_hit          <= 1'b0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      hit_count       <= '0;
      access_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_tag    <= in_tag;
            req_idx    <= in_idx;
            req_off    <= in_off;
            req_din    <= din;
            req_write  <= mem_write;
            lookup_hit <= in_hit;
            is_ready   <= 1'b0;
            state      <= TAG;
            if (in_hit) begin
              is_output_valid <= 1'b1;
              is_hit          <= 1'b1;
              if (!mem_write) dout <= data_arr[in_idx][{in_off, 5'b0} +: 32];
            end
            if (store_hit) dirty[in_idx] <= 1'b1;
          end
        end
        TAG: begin
          if (lookup_hit) begin
            is_output_valid <= 1'b0;
            is_hit          <= 1'b0;
            is_ready        <= 1'b1;
            state           <= IDLE;
            access_count    <= access_count + 32'd1;
            if (is_hit) hit_count <= hit_count + 32'd1;
          end else if (valid[req_idx] && dirty[req_idx]) begin
            state         <= WRITEBACK;
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_addr  <= {tag_arr[req_idx], req_idx, 4'b0};
            mem_req_wdata <= data_arr[req_idx];
          end else begin
            state         <= ALLOCATE;
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_req_addr  <= {req_tag, req_idx, 4'b0};
          end
        end
        WRITEBACK: begin
          if (mem_req_ready) begin
            state         <= ALLOCATE;
            mem_req_write <= 1'b0;
            mem_req_addr  <= {req_tag, req_idx, 4'b0};
          end
        end
        ALLOCATE: begin
          if (mem_req_ready) begin
            state         <= FILL_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid[req_idx]  <= 1'b1;
            dirty[req_idx]  <= req_write;
            lookup_hit      <= 1'b1;
            is_output_valid <= 1'b1;
            is_hit          <= 1'b0;
            if (!req_write) dout <= mem_resp_rdata[{req_off, 5'b0} +: 32];
            state           <= TAG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic against an
// architectural memory model and a line-presence model of a direct-mapped cache.
module tb_data_cache;
  localparam int NSETS = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr, din;
  logic         mem_read, mem_write;
  logic         is_ready, is_output_valid, is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_req_ready, mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [31:0]  hit_count, access_count;

  data_cache #(.NUM_SETS(NSETS), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .mem_read(mem_read), .mem_write(mem_write),
    .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count), .access_count(access_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [31:0] a; logic [127:0] wd; } req_t;

  int n_chk = 0, n_fail = 0;
  int ready_delay = 0, latency = 3;
  bit unstable = 0;
  req_t req_q[$];
  logic [31:0] bmem [int];
  logic [31:0] ref_mem [int];

  // Model state: which line each set holds, and whether it differs from backing memory.
  logic        m_valid [NSETS];
  logic        m_dirty [NSETS];
  logic [31:0] m_line  [NSETS];
  logic        exp_hit;
  logic [31:0] exp_dout;
  int          exp_n, exp_acc, exp_hits;
  req_t        exp_req [2];

  logic        timed_out, obs_hit, obs_rdy_after, rdy_during_miss, intr_rdy;
  logic [31:0] obs_dout;
  int          lat;

  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_rd(input int w);
    return bmem.exists(w) ? bmem[w] : init_word(w);
  endfunction
  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Backing memory: ready after ready_delay cycles, fill data `latency` cycles after acceptance.
  initial begin
    int wait_cnt, resp_cnt, w;
    bit resp_pend;
    logic [127:0] line;
    logic [31:0] cap_a;
    logic cap_w;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    wait_cnt = 0; resp_cnt = 0; resp_pend = 0; line = '0; cap_a = '0; cap_w = 0;
    forever begin
      @(negedge clk);
      mem_req_ready = 0; mem_resp_valid = 0;
      if (reset) begin wait_cnt = 0; resp_pend = 0; continue; end
      if (resp_pend) begin
        if (resp_cnt <= 1) begin mem_resp_valid = 1; mem_resp_rdata = line; resp_pend = 0; end
        else resp_cnt--;
      end else if (mem_req_valid) begin
        if (wait_cnt == 0) begin cap_a = mem_req_addr; cap_w = mem_req_write; end
        else if (cap_a !== mem_req_addr || cap_w !== mem_req_write) unstable = 1;
        if (wait_cnt < ready_delay) wait_cnt++;
        else begin
          mem_req_ready = 1; wait_cnt = 0;
          req_q.push_back('{wr: mem_req_write, a: mem_req_addr, wd: mem_req_wdata});
          w = int'(mem_req_addr >> 2);
          if (mem_req_write) begin
            for (int k = 0; k < 4; k++) bmem[w + k] = mem_req_wdata[k*32 +: 32];
          end else begin
            for (int k = 0; k < 4; k++) line[k*32 +: 32] = mem_rd(w + k);
            resp_pend = 1; resp_cnt = latency;
          end
        end
      end else if (wait_cnt != 0) begin
        unstable = 1; wait_cnt = 0;
      end
    end
  end

  task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int idx, lw;
    logic [31:0] la;
    la = a & ~32'hF; idx = int'((a >> 4) % NSETS); lw = int'(a >> 2);
    exp_hit = m_valid[idx] && (m_line[idx] == la);
    exp_n = 0;
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_req[0].wr = 1; exp_req[0].a = m_line[idx];
        for (int k = 0; k < 4; k++) exp_req[0].wd[k*32 +: 32] = ref_rd(int'(m_line[idx] >> 2) + k);
        exp_n = 1;
      end
      exp_req[exp_n].wr = 0; exp_req[exp_n].a = la; exp_req[exp_n].wd = '0;
      exp_n++;
      m_valid[idx] = 1; m_line[idx] = la; m_dirty[idx] = 0;
    end
    if (wr) begin ref_mem[lw] = d; m_dirty[idx] = 1; end
    else exp_dout = ref_rd(lw);
    exp_acc++;
    if (exp_hit) exp_hits++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSETS; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_line[i] = '0; end
    ref_mem = bmem;
    exp_acc = 0; exp_hits = 0;
  endtask

  // Presents one request as the pipeline would (held while stalled) and records what came back.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit intr);
    int c;
    model_access(wr, a, d);
    req_q.delete();
    c = 0;
    while (!is_ready && c < 100) begin @(negedge clk); c++; end
    addr = a; din = d; mem_write = wr; mem_read = !wr;
    lat = 0; rdy_during_miss = 0; intr_rdy = 1;
    do begin
      @(negedge clk); lat++;
      if (intr && lat == 3) begin
        intr_rdy = is_ready; addr = 32'h60; din = 32'hBAD0_BAD0; mem_write = 1; mem_read = 0;
      end
      if (intr && lat == 4) begin addr = a; din = d; mem_write = wr; mem_read = !wr; end
      if (!is_output_valid && is_ready) rdy_during_miss = 1;
    end while (!is_output_valid && lat < 400);
    timed_out = !is_output_valid; obs_dout = dout; obs_hit = is_hit;
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    obs_rdy_after = is_ready;
  endtask

  task automatic test_reset();
    reset = 1; addr = '0; din = '0; mem_read = 0; mem_write = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #3 reset = 0;
    @(negedge clk);
    n_chk++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL reset_is_ready got %b want 1", is_ready); end
    n_chk++; if (is_output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", is_output_valid); end
    n_chk++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_chk++; if (is_hit !== 1'b0) begin n_fail++; $display("FAIL reset_is_hit got %b want 0", is_hit); end
    n_chk++; if ({mem_req_valid, mem_req_write} !== 2'b00) begin n_fail++; $display("FAIL reset_req got %b want 00", {mem_req_valid, mem_req_write}); end
    n_chk++; if (mem_req_addr !== 32'h0 || mem_req_wdata !== 128'h0) begin n_fail++; $display("FAIL reset_req_fields got %h/%h want 0", mem_req_addr, mem_req_wdata); end
    n_chk++; if (hit_count !== 0 || access_count !== 0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, access_count); end
  endtask

  task automatic test_cold_load();
    bmem[16] = 32'h11; bmem[17] = 32'h22; bmem[18] = 32'h33; bmem[19] = 32'h44;
    ref_mem[16] = 32'h11; ref_mem[17] = 32'h22; ref_mem[18] = 32'h33; ref_mem[19] = 32'h44;
    latency = 3;
    access(0, 32'h40, 0, 0);
    n_chk++; if (req_q.size() != 1 || req_q[0].wr !== 1'b0 || req_q[0].a !== 32'h40) begin n_fail++; $display("FAIL cold_req got n=%0d a=%h want 1 read @40", req_q.size(), (req_q.size() > 0) ? req_q[0].a : 32'hx); end
    n_chk++; if (obs_dout !== 32'h11 || obs_hit !== 1'b0) begin n_fail++; $display("FAIL cold_load got %h hit=%b want 11 hit=0", obs_dout, obs_hit); end
    access(0, 32'h44, 0, 0);
    n_chk++; if (lat != 1 || obs_dout !== 32'h22 || obs_hit !== 1'b1) begin n_fail++; $display("FAIL warm_load got lat=%0d %h hit=%b want lat=1 22 hit=1", lat, obs_dout, obs_hit); end
    n_chk++; if (obs_rdy_after !== 1'b1) begin n_fail++; $display("FAIL warm_ready got %b want 1", obs_rdy_after); end
    n_chk++; if (access_count !== 2 || hit_count !== 1) begin n_fail++; $display("FAIL cold_counters got %0d/%0d want 2/1", access_count, hit_count); end
  endtask

  task automatic test_store_hit();
    access(1, 32'h48, 32'hDEAD_BEEF, 0);
    n_chk++; if (obs_hit !== 1'b1 || req_q.size() != 0) begin n_fail++; $display("FAIL store_hit got hit=%b reqs=%0d want 1/0", obs_hit, req_q.size()); end
    access(0, 32'h48, 0, 0);
    n_chk++; if (obs_dout !== 32'hDEAD_BEEF || obs_hit !== 1'b1 || req_q.size() != 0) begin n_fail++; $display("FAIL store_reload got %h hit=%b reqs=%0d want deadbeef 1 0", obs_dout, obs_hit, req_q.size()); end
  endtask

  task automatic test_dirty_evict();
    access(1, 32'h000, 32'hAA, 0);
    access(0, 32'h100, 0, 0);
    n_chk++; if (req_q.size() != 2) begin n_fail++; $display("FAIL evict_nreq got %0d want 2", req_q.size()); end
    else begin
      n_chk++; if (req_q[0].wr !== 1'b1 || req_q[0].a !== 32'h0 || req_q[0].wd[31:0] !== 32'hAA) begin n_fail++; $display("FAIL evict_wb got wr=%b a=%h w0=%h want 1 0 aa", req_q[0].wr, req_q[0].a, req_q[0].wd[31:0]); end
      n_chk++; if (req_q[1].wr !== 1'b0 || req_q[1].a !== 32'h100) begin n_fail++; $display("FAIL evict_fill got wr=%b a=%h want 0 100", req_q[1].wr, req_q[1].a); end
    end
    n_chk++; if (rdy_during_miss !== 1'b0 || obs_hit !== 1'b0 || obs_dout !== exp_dout) begin n_fail++; $display("FAIL evict_load got rdy=%b hit=%b %h want 0 0 %h", rdy_during_miss, obs_hit, obs_dout, exp_dout); end
  endtask

  task automatic test_write_allocate();
    access(1, 32'h204, 32'h55, 0);
    n_chk++; if (req_q.size() != 1 || req_q[0].wr !== 1'b0 || req_q[0].a !== 32'h200) begin n_fail++; $display("FAIL alloc_req got n=%0d want 1 read @200", req_q.size()); end
    access(0, 32'h204, 0, 0);
    n_chk++; if (obs_dout !== 32'h55 || obs_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_word got %h hit=%b want 55 1", obs_dout, obs_hit); end
    access(0, 32'h200, 0, 0);
    n_chk++; if (obs_dout !== init_word(32'h200 >> 2) || obs_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_neighbor got %h hit=%b want %h 1", obs_dout, obs_hit, init_word(32'h200 >> 2)); end
  endtask

  task automatic test_backpressure();
    ready_delay = 5; latency = 2; unstable = 0;
    access(0, 32'h3050, 0, 1);
    n_chk++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL bp_stable got unstable=%b want 0", unstable); end
    n_chk++; if (req_q.size() != 1 || req_q[0].a !== 32'h3050) begin n_fail++; $display("FAIL bp_single_req got n=%0d want 1 @3050", req_q.size()); end
    n_chk++; if (intr_rdy !== 1'b0 || obs_dout !== init_word(32'h3050 >> 2)) begin n_fail++; $display("FAIL bp_load got rdy=%b %h want 0 %h", intr_rdy, obs_dout, init_word(32'h3050 >> 2)); end
    n_chk++; if (access_count !== exp_acc) begin n_fail++; $display("FAIL bp_count got %0d want %0d", access_count, exp_acc); end
    ready_delay = 0;
    access(0, 32'h60, 0, 0);
    n_chk++; if (obs_hit !== 1'b0 || obs_dout !== init_word(32'h60 >> 2)) begin n_fail++; $display("FAIL bp_ignored got hit=%b %h want 0 %h", obs_hit, obs_dout, init_word(32'h60 >> 2)); end
  endtask

  task automatic test_random();
    logic wr;
    logic [31:0] a, d;
    for (int i = 0; i < 150; i++) begin
      ready_delay = $urandom_range(0, 2); latency = $urandom_range(1, 4);
      wr = 1'($urandom_range(0, 1)); a = $urandom_range(0, 255) << 2; d = $urandom;
      access(wr, a, d, 0);
      n_chk++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout got %b want 0 @%h", timed_out, a); end
      n_chk++; if (obs_hit !== exp_hit) begin n_fail++; $display("FAIL rnd_hit got %b want %b @%h", obs_hit, exp_hit, a); end
      if (!wr) begin
        n_chk++; if (obs_dout !== exp_dout) begin n_fail++; $display("FAIL rnd_dout got %h want %h @%h", obs_dout, exp_dout, a); end
      end
      n_chk++; if (req_q.size() != exp_n) begin n_fail++; $display("FAIL rnd_nreq got %0d want %0d @%h", req_q.size(), exp_n, a); end
      for (int k = 0; k < exp_n && k < req_q.size(); k++) begin
        n_chk++;
        if (req_q[k].wr !== exp_req[k].wr || req_q[k].a !== exp_req[k].a || (exp_req[k].wr && req_q[k].wd !== exp_req[k].wd)) begin
          n_fail++; $display("FAIL rnd_req%0d got %b %h %h want %b %h %h", k, req_q[k].wr, req_q[k].a, req_q[k].wd, exp_req[k].wr, exp_req[k].a, exp_req[k].wd);
        end
      end
      n_chk++; if (obs_rdy_after !== 1'b1 || rdy_during_miss !== 1'b0) begin n_fail++; $display("FAIL rnd_ready got after=%b during=%b want 1 0", obs_rdy_after, rdy_during_miss); end
      n_chk++; if (access_count !== exp_acc || hit_count !== exp_hits) begin n_fail++; $display("FAIL rnd_counters got %0d/%0d want %0d/%0d", access_count, hit_count, exp_acc, exp_hits); end
    end
  endtask

  task automatic test_reset_fill_wait();
    bit found;
    ready_delay = 0; latency = 10;
    req_q.delete();
    addr = 32'h5000; din = '0; mem_read = 1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (req_q.size() > 0 && req_q[req_q.size()-1].wr === 1'b0 && !mem_req_valid) found = 1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL rst_reach_fill got %b want 1", found); end
    #2 reset = 1;
    #1;
    n_chk++; if (mem_req_valid !== 1'b0 || is_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async got valid=%b ready=%b want 0 1", mem_req_valid, is_ready); end
    n_chk++; if (access_count !== 0 || hit_count !== 0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", access_count, hit_count); end
    mem_read = 0;
    @(negedge clk);
    #3 reset = 0;
    @(negedge clk);
    model_reset();
    latency = 3;
    access(0, 32'h5000, 0, 0);
    n_chk++; if (obs_hit !== 1'b0 || obs_dout !== exp_dout) begin n_fail++; $display("FAIL rst_reload got hit=%b %h want 0 %h", obs_hit, obs_dout, exp_dout); end
    n_chk++; if (access_count !== 1 || hit_count !== 0) begin n_fail++; $display("FAIL rst_reload_cnt got %0d/%0d want 1/0", access_count, hit_count); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_write_allocate();
    test_backpressure();
    test_random();
    test_reset_fill_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
